// File: rtl/miner_work_sequencer.sv
// Sequences one mining job into a stream of core packets: load, run, barrier wait, nonce stepping, found/exhausted.
// Optional attempt counter is compiled in when MINER_SEQ_STATS_EN is defined.
module miner_work_sequencer #(
  parameter logic [9:0] CORE_ID_P = 10'd1,
  parameter int         GAP_P     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         work_valid_i,
  output logic         work_ready_o,
  input  logic [255:0] midstate_i,
  input  logic [95:0]  work_i,
  input  logic [31:0]  start_nonce_i,
  input  logic         abort_i,
  input  logic [2:0]   barrier_i,
  output logic [9:0]   pkt_id_o,
  output logic [1:0]   pkt_op_o,
  output logic [9:0]   pkt_addr_o,
  output logic [31:0]  pkt_data_o,
  output logic         busy_o,
  output logic         found_o,
  output logic         exhausted_o,
  output logic [31:0]  found_nonce_o,
  output logic [31:0]  attempts_o
);

  localparam logic [1:0]  OP_NULL   = 2'd0;
  localparam logic [1:0]  OP_REG    = 2'd1;
  localparam logic [1:0]  OP_BAR    = 2'd2;
  localparam logic [1:0]  OP_PC     = 2'd3;
  localparam logic [9:0]  IDLE_ADDR = 10'd24;
  localparam logic [31:0] IDLE_DATA = 32'hFFFF_FFFE;
  localparam int          GAP_W     = (GAP_P > 1) ? $clog2(GAP_P) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_P > 0) ? (GAP_P - 1) : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CMD, S_RUN, S_WAIT, S_GAP, S_NONCE, S_FOUND, S_DRAIN
  } state_t;

  state_t           state_q;
  state_t           after_gap_q;
  logic [3:0]       cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             armed_q;
  logic             first_q;
  logic [255:0]     midstate_q;
  logic [95:0]      work_q;
  logic [31:0]      nonce_q;
  logic [31:0]      found_nonce_q;
  logic             found_q;
  logic             exhausted_q;
  logic [9:0]       pkt_id_q;
  logic [1:0]       pkt_op_q;
  logic [9:0]       pkt_addr_q;
  logic [31:0]      pkt_data_q;
  logic [1:0]       pkt_op_d;
  logic [9:0]       pkt_addr_d;
  logic [31:0]      pkt_data_d;
  logic [31:0]      load_word [0:10];

  // LOAD data words: midstate words 0..7 then header-tail words 0..2
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mid
      assign load_word[gi] = midstate_q[255-32*gi -: 32];
    end
    for (gi = 0; gi < 3; gi++) begin : g_work
      assign load_word[8+gi] = work_q[95-32*gi -: 32];
    end
  endgenerate

  // Packet the current state/step emits on the next edge
  always_comb begin
    pkt_op_d   = OP_NULL;
    pkt_addr_d = IDLE_ADDR;
    pkt_data_d = IDLE_DATA;
    case (state_q)
      S_LOAD: begin
        if (cnt_q == 4'd0) begin
          pkt_op_d   = OP_BAR;
          pkt_data_d = 32'd7;
        end else begin
          pkt_op_d   = OP_REG;
          pkt_addr_d = {6'd0, cnt_q};
          pkt_data_d = load_word[cnt_q - 4'd1];
        end
      end
      S_CMD: begin
        pkt_op_d   = OP_REG;
        pkt_addr_d = 10'd20;
        pkt_data_d = 32'd1;
      end
      S_RUN: begin
        if (cnt_q == 4'd0) begin
          pkt_op_d   = OP_PC;
          pkt_addr_d = 10'd0;
          pkt_data_d = 32'd2;
        end
      end
      S_NONCE: begin
        pkt_op_d   = OP_REG;
        pkt_addr_d = (cnt_q == 4'd0) ? 10'd1 : 10'd20;
        pkt_data_d = (cnt_q == 4'd0) ? nonce_q : 32'd2;
      end
      S_FOUND: begin
        if (cnt_q == 4'd0) begin
          pkt_op_d   = OP_REG;
          pkt_addr_d = 10'd20;
          pkt_data_d = 32'd3;
        end else if (cnt_q == 4'd1) begin
          pkt_op_d   = OP_PC;
          pkt_addr_d = 10'd0;
          pkt_data_d = 32'd2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      after_gap_q   <= S_NONCE;
      cnt_q         <= '0;
      gap_q         <= '0;
      armed_q       <= 1'b0;
      first_q       <= 1'b0;
      midstate_q    <= '0;
      work_q        <= '0;
      nonce_q       <= '0;
      found_nonce_q <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      pkt_id_q      <= CORE_ID_P;
      pkt_op_q      <= OP_NULL;
      pkt_addr_q    <= IDLE_ADDR;
      pkt_data_q    <= IDLE_DATA;
    end else begin
      pkt_id_q    <= CORE_ID_P;
      pkt_op_q    <= pkt_op_d;
      pkt_addr_q  <= pkt_addr_d;
      pkt_data_q  <= pkt_data_d;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      if (state_q == S_NONCE && cnt_q == 4'd0)
        first_q <= 1'b0;
      // Abort lets the in-flight packet go out and beats any barrier resolution
      if (abort_i && state_q != S_IDLE && state_q != S_DRAIN) begin
        state_q <= S_DRAIN;
        cnt_q   <= '0;
        armed_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (work_valid_i) begin
              midstate_q <= midstate_i;
              work_q     <= work_i;
              nonce_q    <= start_nonce_i;
              first_q    <= 1'b1;
              state_q    <= S_LOAD;
              cnt_q      <= '0;
            end
          end
          S_LOAD: begin
            if (cnt_q == 4'd11) begin
              state_q <= S_CMD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_CMD: begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
          S_RUN: begin
            if (cnt_q == 4'd1) begin
              state_q <= S_WAIT;
              armed_q <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_WAIT: begin
            if (!armed_q) begin
              if (barrier_i != 3'd0)
                armed_q <= 1'b1;
            end else if (barrier_i == 3'd0 && !first_q && nonce_q == 32'hFFFF_FFFF) begin
              exhausted_q <= 1'b1;
              state_q     <= S_IDLE;
            end else if (barrier_i == 3'd0 || barrier_i == 3'b001) begin
              if (barrier_i == 3'b001)
                found_nonce_q <= nonce_q;
              else if (!first_q)
                nonce_q <= nonce_q + 32'd1;
              after_gap_q <= (barrier_i == 3'b001) ? S_FOUND : S_NONCE;
              gap_q       <= '0;
              cnt_q       <= '0;
              if (GAP_P == 0)
                state_q <= (barrier_i == 3'b001) ? S_FOUND : S_NONCE;
              else
                state_q <= S_GAP;
            end
          end
          S_GAP: begin
            if (gap_q == GAP_LAST) begin
              state_q <= after_gap_q;
              cnt_q   <= '0;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          S_NONCE: begin
            if (cnt_q == 4'd1) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_FOUND: begin
            if (cnt_q == 4'd2) begin
              found_q <= 1'b1;
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_DRAIN: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef MINER_SEQ_STATS_EN
  logic [31:0] attempts_q;

  // One attempt per nonce packet; saturates rather than wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      attempts_q <= '0;
    else if (state_q == S_IDLE && work_valid_i)
      attempts_q <= '0;
    else if (state_q == S_NONCE && cnt_q == 4'd0 && attempts_q != 32'hFFFF_FFFF)
      attempts_q <= attempts_q + 32'd1;
  end

  assign attempts_o = attempts_q;
`else
  assign attempts_o = '0;
`endif

  assign work_ready_o  = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign found_o       = found_q;
  assign exhausted_o   = exhausted_q;
  assign found_nonce_o = found_nonce_q;
  assign pkt_id_o      = pkt_id_q;
  assign pkt_op_o      = pkt_op_q;
  assign pkt_addr_o    = pkt_addr_q;
  assign pkt_data_o    = pkt_data_q;

endmodule

// File: tb/tb_miner_work_sequencer.sv
// Scoreboard bench for miner_work_sequencer: expected non-idle packets queued at stimulus time, popped as the DUT emits them.
module tb_miner_work_sequencer;

  localparam logic [9:0] CORE_ID = 10'd1;
  localparam int         GAP     = 2;
  localparam logic [1:0] OP_NULL = 2'd0;
  localparam logic [1:0] OP_REG  = 2'd1;
  localparam logic [1:0] OP_BAR  = 2'd2;
  localparam logic [1:0] OP_PC   = 2'd3;
`ifdef MINER_SEQ_STATS_EN
  localparam logic [31:0] EXP_ATTEMPTS = 32'd2;
`else
  localparam logic [31:0] EXP_ATTEMPTS = 32'd0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         work_valid_i = 1'b0;
  logic         work_ready_o;
  logic [255:0] midstate_i = '0;
  logic [95:0]  work_i = '0;
  logic [31:0]  start_nonce_i = '0;
  logic         abort_i = 1'b0;
  logic [2:0]   barrier_i = '0;
  logic [9:0]   pkt_id_o;
  logic [1:0]   pkt_op_o;
  logic [9:0]   pkt_addr_o;
  logic [31:0]  pkt_data_o;
  logic         busy_o, found_o, exhausted_o;
  logic [31:0]  found_nonce_o, attempts_o;

  miner_work_sequencer #(.CORE_ID_P(CORE_ID), .GAP_P(GAP)) dut (
    .clk(clk), .reset(reset),
    .work_valid_i(work_valid_i), .work_ready_o(work_ready_o),
    .midstate_i(midstate_i), .work_i(work_i), .start_nonce_i(start_nonce_i),
    .abort_i(abort_i), .barrier_i(barrier_i),
    .pkt_id_o(pkt_id_o), .pkt_op_o(pkt_op_o), .pkt_addr_o(pkt_addr_o), .pkt_data_o(pkt_data_o),
    .busy_o(busy_o), .found_o(found_o), .exhausted_o(exhausted_o),
    .found_nonce_o(found_nonce_o), .attempts_o(attempts_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  idles;
    logic [1:0]  op;
    logic [9:0]  addr;
    logic [31:0] data;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t obs_q[$];
  pkt_t e, o;
  int   errors = 0;
  int   checks = 0;
  int   idle_run = 0;
  int   bad_idle = 0;
  int   bad_id = 0;
  bit   found_seen = 0;
  bit   exh_seen = 0;
  bit   zero_nonce = 0;

  // Advance one clock, sample 1 time unit after the edge and record what was emitted
  task automatic cycle();
    pkt_t p;
    @(posedge clk);
    #1;
    if (pkt_op_o == OP_NULL) begin
      idle_run++;
      if (pkt_addr_o !== 10'd24 || pkt_data_o !== 32'hFFFF_FFFE) bad_idle++;
    end else begin
      p.idles = (idle_run > 250) ? 8'hFE : idle_run[7:0];
      p.op    = pkt_op_o;
      p.addr  = pkt_addr_o;
      p.data  = pkt_data_o;
      obs_q.push_back(p);
      idle_run = 0;
      if (pkt_op_o == OP_REG && pkt_addr_o == 10'd1 && pkt_data_o == 32'd0) zero_nonce = 1;
    end
    if (pkt_id_o !== CORE_ID) bad_id++;
    if (found_o) found_seen = 1;
    if (exhausted_o) exh_seen = 1;
  endtask

  task automatic push(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] data,
                      input logic [7:0] idles);
    pkt_t p;
    p.idles = idles;
    p.op    = op;
    p.addr  = addr;
    p.data  = data;
    exp_q.push_back(p);
  endtask

  // Drive one job into IDLE and queue its LOAD/CMD/RUN packets
  task automatic accept(input logic [31:0] sn);
    for (int k = 0; k < 8; k++) midstate_i[255-32*k -: 32] = $urandom;
    for (int k = 0; k < 3; k++) work_i[95-32*k -: 32] = $urandom;
    start_nonce_i = sn;
    push(OP_BAR, 10'd24, 32'd7, 8'hFF);
    for (int k = 0; k < 8; k++) push(OP_REG, 10'(k + 1), midstate_i[255-32*k -: 32], 8'd0);
    for (int k = 0; k < 3; k++) push(OP_REG, 10'(k + 9), work_i[95-32*k -: 32], 8'd0);
    push(OP_REG, 10'd20, 32'd1, 8'd0);
    push(OP_PC, 10'd0, 32'd2, 8'd0);
    work_valid_i = 1'b1;
    cycle();
    work_valid_i = 1'b0;
  endtask

  // Settle in WAIT with barrier 0, arm with 7, then present the resolving value
  task automatic resolve(input logic [2:0] v, input bit ab);
    barrier_i = 3'd0;
    repeat (3) cycle();
    barrier_i = 3'd7;
    cycle();
    barrier_i = v;
    abort_i = ab;
    cycle();
    abort_i = 1'b0;
    barrier_i = 3'd0;
    idle_run = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (pkt_op_o !== OP_NULL || pkt_addr_o !== 10'd24 || pkt_data_o !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL reset_pkt got op=%0d addr=%0d data=%08h want op=0 addr=24 data=fffffffe", pkt_op_o, pkt_addr_o, pkt_data_o);
    end
    checks++;
    if (pkt_id_o !== CORE_ID) begin errors++; $display("FAIL reset_id got=%0d want=%0d", pkt_id_o, CORE_ID); end
    checks++;
    if ({busy_o, found_o, exhausted_o} !== 3'b000) begin
      errors++; $display("FAIL reset_status got=%b want=000", {busy_o, found_o, exhausted_o});
    end
    checks++;
    if (found_nonce_o !== 32'd0 || attempts_o !== 32'd0) begin
      errors++; $display("FAIL reset_counts got found_nonce=%0d attempts=%0d want 0 0", found_nonce_o, attempts_o);
    end
    @(negedge clk) reset = 1'b1;
    cycle();
    checks++;
    if (work_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", work_ready_o); end
    $display("reset: outputs checked");
  endtask

  task automatic test_load();
    accept(32'd8);
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) cycle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL load_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.op !== e.op || o.addr !== e.addr || o.data !== e.data || (e.idles != 8'hFF && o.idles !== e.idles)) begin
        errors++;
        $display("FAIL load_pkt got op=%0d addr=%0d data=%08h idles=%0d want op=%0d addr=%0d data=%08h idles=%0d",
                 o.op, o.addr, o.data, o.idles, e.op, e.addr, e.data, e.idles);
      end else $display("load: op=%0d addr=%0d data=%08h", o.op, o.addr, o.data);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_unarmed();
    barrier_i = 3'd0;
    repeat (12) cycle();
    checks++;
    if (obs_q.size() != 0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL unarmed_hold got pkts=%0d busy=%b want pkts=0 busy=1", obs_q.size(), busy_o);
    end
    $display("unarmed: barrier 0 ignored for 12 cycles");
    obs_q.delete();
  endtask

  task automatic test_nonce();
    for (int r = 0; r < 2; r++) begin
      resolve(3'd0, 1'b0);
      push(OP_REG, 10'd1, 32'd8 + 32'(r), 8'(GAP));
      push(OP_REG, 10'd20, 32'd2, 8'd0);
      push(OP_PC, 10'd0, 32'd2, 8'd0);
      for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) cycle();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL nonce_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL nonce_pkt got op=%0d addr=%0d data=%08h idles=%0d want op=%0d addr=%0d data=%08h idles=%0d",
                   o.op, o.addr, o.data, o.idles, e.op, e.addr, e.data, e.idles);
        end else $display("nonce: op=%0d addr=%0d data=%08h idles=%0d", o.op, o.addr, o.data, o.idles);
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_found();
    found_seen = 0; exh_seen = 0;
    resolve(3'd1, 1'b0);
    push(OP_REG, 10'd20, 32'd3, 8'(GAP));
    push(OP_PC, 10'd0, 32'd2, 8'd0);
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) cycle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL found_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL found_pkt got op=%0d addr=%0d data=%08h idles=%0d want op=%0d addr=%0d data=%08h idles=%0d",
                 o.op, o.addr, o.data, o.idles, e.op, e.addr, e.data, e.idles);
      end else $display("found: op=%0d addr=%0d data=%08h", o.op, o.addr, o.data);
    end
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 10 && !found_seen; i++) cycle();
    checks++;
    if (!found_seen || exh_seen) begin
      errors++; $display("FAIL found_pulse got found=%b exhausted=%b want 1 0", found_seen, exh_seen);
    end
    checks++;
    if (found_nonce_o !== 32'd9) begin errors++; $display("FAIL found_nonce got=%0d want=9", found_nonce_o); end
    checks++;
    if (attempts_o !== EXP_ATTEMPTS) begin
      errors++; $display("FAIL attempts got=%0d want=%0d", attempts_o, EXP_ATTEMPTS);
    end
    checks++;
    if (busy_o !== 1'b0 || obs_q.size() != 0) begin
      errors++; $display("FAIL found_idle got busy=%b pkts=%0d want busy=0 pkts=0", busy_o, obs_q.size());
    end
    cycle();
    checks++;
    if (found_o !== 1'b0) begin errors++; $display("FAIL found_width got=%b want=0", found_o); end
    $display("found: pulse, nonce=%0d attempts=%0d", found_nonce_o, attempts_o);
  endtask

  task automatic test_abort_resolve();
    found_seen = 0; exh_seen = 0;
    accept(32'd20);
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) cycle();
    exp_q.delete(); obs_q.delete();
    resolve(3'd1, 1'b1);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL abres_drain got busy=%b want=1", busy_o); end
    repeat (6) cycle();
    checks++;
    if (busy_o !== 1'b0 || obs_q.size() != 0 || found_seen || exh_seen) begin
      errors++;
      $display("FAIL abres_end got busy=%b pkts=%0d found=%b exh=%b want 0 0 0 0", busy_o, obs_q.size(), found_seen, exh_seen);
    end
    checks++;
    if (found_nonce_o !== 32'd9) begin errors++; $display("FAIL abres_nonce got=%0d want=9", found_nonce_o); end
    $display("abort+resolve: drained, no status");
    obs_q.delete();
  endtask

  task automatic test_exhaust();
    found_seen = 0; exh_seen = 0;
    accept(32'hFFFF_FFFF);
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) cycle();
    exp_q.delete(); obs_q.delete();
    resolve(3'd0, 1'b0);
    push(OP_REG, 10'd1, 32'hFFFF_FFFF, 8'(GAP));
    push(OP_REG, 10'd20, 32'd2, 8'd0);
    push(OP_PC, 10'd0, 32'd2, 8'd0);
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) cycle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL exh_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL exh_pkt got op=%0d addr=%0d data=%08h idles=%0d want op=%0d addr=%0d data=%08h idles=%0d",
                 o.op, o.addr, o.data, o.idles, e.op, e.addr, e.data, e.idles);
      end else $display("exhaust: op=%0d addr=%0d data=%08h", o.op, o.addr, o.data);
    end
    exp_q.delete(); obs_q.delete();
    resolve(3'd0, 1'b0);
    checks++;
    if (!exh_seen || busy_o !== 1'b0) begin
      errors++; $display("FAIL exh_pulse got exhausted=%b busy=%b want 1 0", exh_seen, busy_o);
    end
    repeat (6) cycle();
    checks++;
    if (obs_q.size() != 0 || found_seen) begin
      errors++; $display("FAIL exh_after got pkts=%0d found=%b want 0 0", obs_q.size(), found_seen);
    end
    obs_q.delete();
  endtask

  task automatic test_abort_load();
    found_seen = 0; exh_seen = 0;
    accept(32'd3);
    while (exp_q.size() > 7) void'(exp_q.pop_back());
    for (int i = 0; i < 20 && obs_q.size() < 6; i++) cycle();
    abort_i = 1'b1;
    cycle();
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_drain got busy=%b want=1", busy_o); end
    cycle();
    checks++;
    if (busy_o !== 1'b0 || pkt_op_o !== OP_NULL) begin
      errors++; $display("FAIL abort_idle got busy=%b op=%0d want busy=0 op=0", busy_o, pkt_op_o);
    end
    repeat (5) cycle();
    checks++;
    if (obs_q.size() != exp_q.size() || found_seen || exh_seen) begin
      errors++;
      $display("FAIL abort_count got pkts=%0d found=%b exh=%b want pkts=%0d 0 0", obs_q.size(), found_seen, exh_seen, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.op !== e.op || o.addr !== e.addr || o.data !== e.data) begin
        errors++;
        $display("FAIL abort_pkt got op=%0d addr=%0d data=%08h want op=%0d addr=%0d data=%08h",
                 o.op, o.addr, o.data, e.op, e.addr, e.data);
      end else $display("abort: op=%0d addr=%0d data=%08h", o.op, o.addr, o.data);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    accept(32'd5);
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) cycle();
    exp_q.delete(); obs_q.delete();
    barrier_i = 3'd7;
    repeat (3) cycle();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pkt_op_o !== OP_NULL || pkt_addr_o !== 10'd24 || pkt_data_o !== 32'hFFFF_FFFE || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got op=%0d addr=%0d data=%08h busy=%b want 0 24 fffffffe 0", pkt_op_o, pkt_addr_o, pkt_data_o, busy_o);
    end
    barrier_i = 3'd0;
    @(negedge clk) reset = 1'b1;
    cycle();
    checks++;
    if (pkt_op_o !== OP_NULL || busy_o !== 1'b0 || work_ready_o !== 1'b1 || attempts_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_after got op=%0d busy=%b ready=%b attempts=%0d want 0 0 1 0", pkt_op_o, busy_o, work_ready_o, attempts_o);
    end
    $display("reset mid-job: idle outputs");
    obs_q.delete();
  endtask

  task automatic test_final();
    checks++;
    if (bad_idle != 0) begin errors++; $display("FAIL idle_fields got bad=%0d want=0", bad_idle); end
    checks++;
    if (bad_id != 0) begin errors++; $display("FAIL pkt_id got bad=%0d want=0", bad_id); end
    checks++;
    if (zero_nonce) begin errors++; $display("FAIL nonce_zero got issued=1 want=0"); end
  endtask

  initial begin
    #12;
    test_reset();
    test_load();
    test_unarmed();
    test_nonce();
    test_found();
    test_abort_resolve();
    test_exhaust();
    test_abort_load();
    test_reset_mid();
    test_final();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
